// File: rtl/sap_pkg.sv
// Shared SAP-1 definitions: control-word bit positions, opcodes and the idle word.
// The controller imports this package as well, so both sides agree on encodings.
package sap_pkg;

  localparam int CP   = 11;
  localparam int EP   = 10;
  localparam int LM_N = 9;
  localparam int CE_N = 8;
  localparam int LI_N = 7;
  localparam int EI_N = 6;
  localparam int LA_N = 5;
  localparam int EA   = 4;
  localparam int SU   = 3;
  localparam int EU   = 2;
  localparam int LB_N = 1;
  localparam int LO_N = 0;

  localparam logic [3:0] LDA = 4'h0;
  localparam logic [3:0] ADD = 4'h1;
  localparam logic [3:0] SUB = 4'h2;
  localparam logic [3:0] OUT = 4'hE;
  localparam logic [3:0] HLT = 4'hF;

  localparam logic [11:0] NOP_WORD = 12'h3E3;

  typedef enum logic [2:0] {
    SRC_NONE,
    SRC_PC,
    SRC_RAM,
    SRC_IR,
    SRC_A,
    SRC_ALU
  } bus_src_e;

endpackage

// File: rtl/sap_ram16x8.sv
// 16x8 program/data memory: asynchronous read addressed by MAR, synchronous
// write from the programming port. Contents survive reset.
module sap_ram16x8 #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clock,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clock) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sap_datapath.sv
// SAP-1 datapath: W-bus mux, PC/MAR/IR/A/B/OUT registers and the adder/subtractor,
// executing one control word per clock and reporting the opcode back.
module sap_datapath
  import sap_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [11:0]           control_word,
  input  logic                  prog_en,
  input  logic                  prog_we,
  input  logic [ADDR_WIDTH-1:0] prog_addr,
  input  logic [DATA_WIDTH-1:0] prog_data,
  output logic [3:0]            instruction,
  output logic [DATA_WIDTH-1:0] out_value,
  output logic [DATA_WIDTH-1:0] w_bus,
  output logic                  halted,
  output logic                  bus_error
);

  localparam int PAD = DATA_WIDTH - ADDR_WIDTH;

  logic cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo;
  assign cp = control_word[CP];
  assign ep = control_word[EP];
  assign lm = ~control_word[LM_N];
  assign ce = ~control_word[CE_N];
  assign li = ~control_word[LI_N];
  assign ei = ~control_word[EI_N];
  assign la = ~control_word[LA_N];
  assign ea = control_word[EA];
  assign su = control_word[SU];
  assign eu = control_word[EU];
  assign lb = ~control_word[LB_N];
  assign lo = ~control_word[LO_N];

  logic [ADDR_WIDTH-1:0] pc_q, pc_d, mar_q, mar_d;
  logic [DATA_WIDTH-1:0] ir_q, ir_d, a_q, a_d, b_q, b_d, out_q, out_d;
  logic                  bus_err_q, bus_err_d;
  logic [DATA_WIDTH-1:0] ram_rdata, alu_res, bus;
  logic [2:0]            n_drv;
  logic                  run_en;
  bus_src_e              bus_src;

  sap_ram16x8 #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clock(clock),
    .we   (prog_en & prog_we),
    .waddr(prog_addr),
    .wdata(prog_data),
    .raddr(mar_q),
    .rdata(ram_rdata)
  );

  assign alu_res = su ? (a_q - b_q) : (a_q + b_q);

  // Contention resolves by fixed priority; the conflict itself is latched in bus_error.
  always_comb begin
    bus_src = SRC_NONE;
    if (ep)      bus_src = SRC_PC;
    else if (ce) bus_src = SRC_RAM;
    else if (ei) bus_src = SRC_IR;
    else if (ea) bus_src = SRC_A;
    else if (eu) bus_src = SRC_ALU;
  end

  always_comb begin
    case (bus_src)
      SRC_PC:  bus = {{PAD{1'b0}}, pc_q};
      SRC_RAM: bus = ram_rdata;
      SRC_IR:  bus = {{PAD{1'b0}}, ir_q[ADDR_WIDTH-1:0]};
      SRC_A:   bus = a_q;
      SRC_ALU: bus = alu_res;
      default: bus = '0;
    endcase
  end

  assign n_drv = {2'b00, ep} + {2'b00, ce} + {2'b00, ei} + {2'b00, ea} + {2'b00, eu};

  assign instruction = ir_q[DATA_WIDTH-1 -: 4];
  assign halted      = (instruction == HLT);
  assign run_en      = ~prog_en & ~halted;

  always_comb begin
    pc_d      = pc_q;
    mar_d     = mar_q;
    ir_d      = ir_q;
    a_d       = a_q;
    b_d       = b_q;
    out_d     = out_q;
    bus_err_d = bus_err_q | (~prog_en & (n_drv > 3'd1));
    if (run_en) begin
      if (cp) pc_d  = pc_q + 1'b1;
      if (lm) mar_d = bus[ADDR_WIDTH-1:0];
      if (li) ir_d  = bus;
      if (la) a_d   = bus;
      if (lb) b_d   = bus;
      if (lo) out_d = bus;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc_q      <= '0;
      mar_q     <= '0;
      ir_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      out_q     <= '0;
      bus_err_q <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      mar_q     <= mar_d;
      ir_q      <= ir_d;
      a_q       <= a_d;
      b_q       <= b_d;
      out_q     <= out_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign out_value = out_q;
  assign w_bus     = bus;
  assign bus_error = bus_err_q;

endmodule

// File: tb/tb_sap_datapath.sv
// Self-checking bench: emulates the controller's microcode, predicts program
// results with an instruction-level model, and scoreboards every OUT load.
module tb_sap_datapath;
  import sap_pkg::*;

  localparam logic [11:0] W_T1     = 12'h5E3;
  localparam logic [11:0] W_T2     = 12'hBE3;
  localparam logic [11:0] W_T3     = 12'h263;
  localparam logic [11:0] W_ADR    = 12'h1A3;
  localparam logic [11:0] W_LDA5   = 12'h2C3;
  localparam logic [11:0] W_LDB5   = 12'h2E1;
  localparam logic [11:0] W_ADD6   = 12'h3C7;
  localparam logic [11:0] W_SUB6   = 12'h3CF;
  localparam logic [11:0] W_OUT4   = 12'h3F2;
  localparam logic [11:0] PEEK_PC  = 12'h7E3;
  localparam logic [11:0] PEEK_RAM = 12'h2E3;
  localparam logic [11:0] PEEK_IR  = 12'h3A3;
  localparam logic [11:0] PEEK_A   = 12'h3F3;
  localparam logic [11:0] W_CONF   = 12'h5F3;

  logic        clock;
  logic        reset_n;
  logic [11:0] control_word;
  logic        prog_en, prog_we;
  logic [3:0]  prog_addr;
  logic [7:0]  prog_data;
  logic [3:0]  instruction;
  logic [7:0]  out_value, w_bus;
  logic        halted, bus_error;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] shadow [16];
  logic [7:0] img [16];
  logic [7:0] exp_q [$];

  sap_datapath #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .clock(clock), .reset_n(reset_n), .control_word(control_word),
    .prog_en(prog_en), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .instruction(instruction), .out_value(out_value), .w_bus(w_bus),
    .halted(halted), .bus_error(bus_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %02h, expected %02h", name, act, expv);
    end else begin
      $display("ok   %s: %02h", name, act);
    end
  endtask

  // Monitor: every edge that loads OUT must match the next predicted output.
  logic lo_fire_q;
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) lo_fire_q <= 1'b0;
    else          lo_fire_q <= !prog_en && !control_word[LO_N];
  end

  always @(negedge clock) begin
    if (lo_fire_q) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL out_unexpected: got %02h, expected no OUT load", out_value);
      end else begin
        chk("out_value", out_value, exp_q.pop_front());
      end
    end
  end

  task automatic step(input logic [11:0] w);
    control_word = w;
    @(posedge clock);
    #1;
  endtask

  task automatic peek(input logic [11:0] w, output logic [7:0] v);
    control_word = w;
    #1;
    v = w_bus;
  endtask

  task automatic do_reset();
    control_word = NOP_WORD;
    #1 reset_n = 1'b0;
    #1 reset_n = 1'b1;
    @(posedge clock);
    #1;
  endtask

  task automatic prog_write(input logic [3:0] a, input logic [7:0] d);
    prog_en = 1'b1; prog_we = 1'b1; prog_addr = a; prog_data = d;
    shadow[a] = d;
    @(posedge clock);
    #1;
    prog_en = 1'b0; prog_we = 1'b0;
  endtask

  task automatic write_img();
    for (int i = 0; i < 16; i++) prog_write(i[3:0], img[i]);
  endtask

  // Instruction-level reference: runs the program in shadow RAM, queues OUT values.
  task automatic model_run(input int max_i, output logic [3:0] pc, output logic [7:0] a);
    logic [7:0] ir;
    pc = 4'd0;
    a  = 8'd0;
    for (int i = 0; i < max_i; i++) begin
      ir = shadow[pc];
      pc = pc + 4'd1;
      if (ir[7:4] == HLT) break;
      case (ir[7:4])
        LDA: a = shadow[ir[3:0]];
        ADD: a = a + shadow[ir[3:0]];
        SUB: a = a - shadow[ir[3:0]];
        OUT: exp_q.push_back(a);
        default: ;
      endcase
    end
  endtask

  // Controller emulation: fetch, then decode on the returned opcode.
  task automatic run_cpu(input int max_i, output bit hs);
    logic [3:0] op;
    hs = 1'b0;
    for (int i = 0; i < max_i; i++) begin
      step(W_T1); step(W_T2); step(W_T3);
      op = instruction;
      if (op == HLT) begin
        hs = 1'b1;
        break;
      end
      case (op)
        LDA:     begin step(W_ADR); step(W_LDA5); step(NOP_WORD); end
        ADD:     begin step(W_ADR); step(W_LDB5); step(W_ADD6);   end
        SUB:     begin step(W_ADR); step(W_LDB5); step(W_SUB6);   end
        OUT:     begin step(W_OUT4); step(NOP_WORD); step(NOP_WORD); end
        default: begin step(NOP_WORD); step(NOP_WORD); step(NOP_WORD); end
      endcase
    end
  endtask

  task automatic run_full(input string tag);
    logic [3:0] mpc;
    logic [7:0] ma, v;
    bit hs;
    do_reset();
    model_run(16, mpc, ma);
    run_cpu(16, hs);
    chk({tag, "_halted"}, {7'd0, halted}, 8'd1);
    chk({tag, "_halt_seen"}, {7'd0, hs}, 8'd1);
    step(W_T2); step(W_LDA5);
    peek(PEEK_PC, v); chk({tag, "_pc_frozen"}, v, {4'd0, mpc});
    peek(PEEK_A, v);  chk({tag, "_a_final"}, v, ma);
    chk({tag, "_bus_error"}, {7'd0, bus_error}, 8'd0);
    chk({tag, "_queue_empty"}, 8'(exp_q.size()), 8'd0);
    exp_q.delete();
    control_word = NOP_WORD;
  endtask

  initial begin
    logic [7:0] v;
    logic [3:0] mpc;
    logic [7:0] ma;
    bit hs;
    int n;
    int r;

    control_word = NOP_WORD;
    prog_en = 1'b0; prog_we = 1'b0; prog_addr = 4'd0; prog_data = 8'd0;
    reset_n = 1'b0;
    #3;
    chk("rst_instruction", {4'd0, instruction}, 8'd0);
    chk("rst_out_value", out_value, 8'd0);
    chk("rst_w_bus", w_bus, 8'd0);
    chk("rst_halted", {7'd0, halted}, 8'd0);
    chk("rst_bus_error", {7'd0, bus_error}, 8'd0);
    @(posedge clock);
    #3 reset_n = 1'b1;
    @(posedge clock);
    #1;

    // Fetch sequence
    prog_write(4'd0, 8'h1A);
    do_reset();
    step(W_T1);
    peek(PEEK_RAM, v); chk("fetch_mar0_ram", v, 8'h1A);
    step(W_T2);
    peek(PEEK_PC, v);  chk("fetch_pc1", v, 8'h01);
    step(W_T3);
    chk("fetch_instruction", {4'd0, instruction}, 8'h01);
    peek(PEEK_IR, v);  chk("fetch_ir_low", v, 8'h0A);
    step(NOP_WORD); step(NOP_WORD);
    peek(PEEK_PC, v);  chk("nop_pc_hold", v, 8'h01);
    chk("nop_ir_hold", {4'd0, instruction}, 8'h01);

    // Full reference program
    img = '{8'h09, 8'h1A, 8'h2B, 8'hE0, 8'hF0, 8'h00, 8'h00, 8'h00,
            8'h00, 8'h10, 8'h14, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00};
    write_img();
    run_full("prog");
    chk("prog_out_value", out_value, 8'h20);

    // Arithmetic wrap: ADD and SUB
    img = '{8'h08, 8'h19, 8'hE0, 8'hF0, 8'h00, 8'h00, 8'h00, 8'h00,
            8'hF0, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    write_img();
    run_full("addwrap");
    chk("addwrap_result", out_value, 8'h10);
    img = '{8'h08, 8'h29, 8'hE0, 8'hF0, 8'h00, 8'h00, 8'h00, 8'h00,
            8'h05, 8'h07, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    write_img();
    run_full("subwrap");
    chk("subwrap_result", out_value, 8'hFE);

    // PC wrap
    do_reset();
    for (int i = 0; i < 15; i++) step(W_T2);
    peek(PEEK_PC, v); chk("pc_at_15", v, 8'h0F);
    step(W_T2);
    peek(PEEK_PC, v); chk("pc_wrap_0", v, 8'h00);

    // Bus conflict
    prog_write(4'd0, 8'h5A);
    do_reset();
    step(W_LDA5);
    step(W_T2); step(W_T2); step(W_T2);
    chk("conf_pre_bus_error", {7'd0, bus_error}, 8'd0);
    peek(W_CONF, v); chk("conf_w_bus_pc", v, 8'h03);
    step(W_CONF);
    chk("conf_bus_error_set", {7'd0, bus_error}, 8'd1);
    step(NOP_WORD); step(NOP_WORD); step(NOP_WORD);
    chk("conf_bus_error_sticky", {7'd0, bus_error}, 8'd1);
    do_reset();
    chk("conf_bus_error_clr", {7'd0, bus_error}, 8'd0);

    // Programming hold
    control_word = W_T2;
    prog_en = 1'b1; prog_we = 1'b1; prog_addr = 4'd0; prog_data = 8'h77;
    shadow[0] = 8'h77;
    @(posedge clock);
    #1;
    prog_en = 1'b0; prog_we = 1'b0;
    peek(PEEK_PC, v);  chk("prog_hold_pc", v, 8'h00);
    peek(PEEK_RAM, v); chk("prog_write_lands", v, 8'h77);

    // Mid-run reset with A=0x55, PC=7
    img = '{8'h0F, 8'hE0, 8'hE0, 8'hE0, 8'hE0, 8'hE0, 8'hE0, 8'hF0,
            8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h55};
    write_img();
    do_reset();
    model_run(6, mpc, ma);
    run_cpu(6, hs);
    step(W_T1); step(W_T2);
    peek(PEEK_PC, v); chk("midrun_pc", v, 8'h07);
    peek(PEEK_A, v);  chk("midrun_a", v, 8'h55);
    #1 reset_n = 1'b0;
    #1;
    chk("midrst_out_value", out_value, 8'h00);
    chk("midrst_instruction", {4'd0, instruction}, 8'h00);
    chk("midrst_halted", {7'd0, halted}, 8'd0);
    chk("midrst_bus_error", {7'd0, bus_error}, 8'd0);
    peek(PEEK_A, v);  chk("midrst_a", v, 8'h00);
    peek(PEEK_PC, v); chk("midrst_pc", v, 8'h00);
    control_word = NOP_WORD;
    #1 reset_n = 1'b1;
    @(posedge clock);
    #1;
    chk("midrst_queue_empty", 8'(exp_q.size()), 8'd0);
    run_full("rerun");

    // Randomized programs against the instruction-level model
    for (int t = 0; t < 8; t++) begin
      n = $urandom_range(1, 7);
      for (int a = 0; a < 16; a++) img[a] = 8'($urandom);
      for (int a = 0; a < n; a++) begin
        r = $urandom_range(0, 3);
        img[a] = {(r == 3) ? OUT : 4'(r), 4'($urandom_range(8, 15))};
      end
      img[n] = {HLT, 4'h0};
      write_img();
      run_full($sformatf("rand%0d", t));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
